// File: rtl/pll_lock_supervisor.sv
// pll_lock_supervisor: qualifies PLL lock on refclk, retries the PLL on lock timeout and sequences the core reset
module pll_lock_supervisor #(
  parameter int PLL_RST_CYCLES = 16,
  parameter int LOCK_TIMEOUT   = 500000,
  parameter int STABLE_CYCLES  = 1024,
  parameter int CNT_W          = 8
) (
  input  logic             refclk,
  input  logic             rst,
  input  logic             soft_reset,
  input  logic             pll_locked,
  output logic             pll_rst,
  output logic             core_reset,
  output logic             ready,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] retry_count,
  output logic [CNT_W-1:0] lock_lost_count
);
  localparam int PW = PLL_RST_CYCLES > 1 ? $clog2(PLL_RST_CYCLES) : 1;
  localparam int TW = LOCK_TIMEOUT > 1 ? $clog2(LOCK_TIMEOUT) : 1;
  localparam int SW = STABLE_CYCLES > 1 ? $clog2(STABLE_CYCLES) : 1;
  localparam logic [PW-1:0] PC_MAX = PW'(PLL_RST_CYCLES - 1);
  localparam logic [TW-1:0] TO_MAX = TW'(LOCK_TIMEOUT - 1);
  localparam logic [SW-1:0] SC_MAX = SW'(STABLE_CYCLES - 1);
  typedef enum logic [1:0] {PLL_RST = 2'd0, WAIT_LOCK = 2'd1, STABLE = 2'd2, RUN = 2'd3} state_t;
  state_t           state_q, state_d;
  logic [PW-1:0]    pc_q, pc_d;
  logic [TW-1:0]    to_q, to_d;
  logic [SW-1:0]    sc_q, sc_d;
  logic [CNT_W-1:0] retry_q, retry_d, lost_q, lost_d;
  logic             sync_q, lock_s_q, pll_rst_q, core_reset_q, ready_q;
  logic             timeout, lost, qualified;
  always_comb begin
    state_d   = state_q;
    pc_d      = '0;
    to_d      = '0;
    sc_d      = '0;
    timeout   = 1'b0;
    lost      = 1'b0;
    qualified = lock_s_q && sc_q == SC_MAX;
    unique case (state_q)
      PLL_RST: begin
        pc_d    = pc_q == PC_MAX ? '0 : pc_q + 1'b1;
        state_d = pc_q == PC_MAX ? WAIT_LOCK : PLL_RST;
      end
      WAIT_LOCK: begin
        timeout = to_q == TO_MAX;
        to_d    = timeout ? '0 : to_q + 1'b1;
        state_d = timeout ? PLL_RST : lock_s_q ? STABLE : WAIT_LOCK;
      end
      STABLE: begin
        // the timeout keeps running across lock flaps; only a completed qualification beats it
        timeout = to_q == TO_MAX && !qualified;
        to_d    = timeout || qualified ? '0 : to_q + 1'b1;
        sc_d    = lock_s_q && !qualified ? sc_q + 1'b1 : '0;
        state_d = qualified ? RUN : timeout ? PLL_RST : lock_s_q ? STABLE : WAIT_LOCK;
      end
      RUN: begin
        lost    = !lock_s_q;
        state_d = lost ? WAIT_LOCK : soft_reset ? STABLE : RUN;
      end
    endcase
    retry_d = retry_q + CNT_W'(timeout && !(&retry_q));
    lost_d  = lost_q + CNT_W'(lost && !(&lost_q));
  end
  always_ff @(posedge refclk) begin
    if (rst) begin
      state_q      <= PLL_RST;
      pc_q         <= '0;
      to_q         <= '0;
      sc_q         <= '0;
      retry_q      <= '0;
      lost_q       <= '0;
      sync_q       <= 1'b0;
      lock_s_q     <= 1'b0;
      pll_rst_q    <= 1'b1;
      core_reset_q <= 1'b1;
      ready_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      to_q         <= to_d;
      sc_q         <= sc_d;
      retry_q      <= retry_d;
      lost_q       <= lost_d;
      sync_q       <= pll_locked;
      lock_s_q     <= sync_q;
      pll_rst_q    <= state_d == PLL_RST;
      core_reset_q <= state_d != RUN;
      ready_q      <= state_d == RUN;
    end
  end
  assign pll_rst         = pll_rst_q;
  assign core_reset      = core_reset_q;
  assign ready           = ready_q;
  assign state           = state_q;
  assign retry_count     = retry_q;
  assign lock_lost_count = lost_q;
endmodule

// File: tb/tb_pll_lock_supervisor.sv
// tb_pll_lock_supervisor: randomized and directed checks of pll_lock_supervisor against a behavioural model
module tb_pll_lock_supervisor;
  localparam int P = 4, LT = 100, S = 16, W = 8;
  logic clk = 1'b0, rst = 1'b1, soft_reset = 1'b0, pll_locked = 1'b0;
  logic pll_rst, core_reset, ready;
  logic [1:0] state;
  logic [W-1:0] retry_count, lock_lost_count;
  logic [22:0] obs;
  int n_run = 0, n_fail = 0;
  int m_state, m_pc, m_to, m_st, m_retry, m_lost;
  bit hist[$];
  pll_lock_supervisor #(.PLL_RST_CYCLES(P), .LOCK_TIMEOUT(LT), .STABLE_CYCLES(S), .CNT_W(W)) dut (
    .refclk(clk), .rst(rst), .soft_reset(soft_reset), .pll_locked(pll_locked),
    .pll_rst(pll_rst), .core_reset(core_reset), .ready(ready), .state(state),
    .retry_count(retry_count), .lock_lost_count(lock_lost_count)
  );
  always #5 clk = ~clk;
  assign obs = {pll_rst, core_reset, ready, state, retry_count, lock_lost_count};
  function automatic logic [22:0] mexp();
    return {m_state == 0, m_state != 3, m_state == 3, 2'(m_state), 8'(m_retry), 8'(m_lost)};
  endfunction
  task automatic mstep(input bit r, input bit s, input bit l);
    bit ls;
    ls = hist.size() >= 2 ? hist[hist.size()-2] : 1'b0;
    if (r) begin
      m_state = 0; m_pc = 0; m_to = 0; m_st = 0; m_retry = 0; m_lost = 0;
      hist.delete();
      return;
    end
    hist.push_back(l);
    if (hist.size() > 4) void'(hist.pop_front());
    case (m_state)
      0: if (m_pc == P - 1) begin m_state = 1; m_pc = 0; end else m_pc++;
      1, 2: begin
        if (m_state == 2 && ls && m_st == S - 1) begin
          m_state = 3; m_to = 0;
        end else if (m_to == LT - 1) begin
          m_state = 0; m_to = 0; m_pc = 0;
          if (m_retry < 255) m_retry++;
        end else begin
          m_to++;
          if (!ls) begin m_state = 1; m_st = 0; end
          else if (m_state == 1) begin m_state = 2; m_st = 0; end
          else m_st++;
        end
      end
      default: begin
        if (!ls) begin
          m_state = 1; m_to = 0;
          if (m_lost < 255) m_lost++;
        end else if (s) begin
          m_state = 2; m_st = 0; m_to = 0;
        end
      end
    endcase
  endtask
  task automatic step(input bit r, input bit s, input bit l);
    @(negedge clk);
    rst = r; soft_reset = s; pll_locked = l;
    @(posedge clk);
    mstep(r, s, l);
    #1;
  endtask
  task automatic test_reset();
    for (int k = 0; k < 5; k++) begin
      step(1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      n_run++;
      if (obs !== mexp()) begin n_fail++; $display("FAIL reset_cycle k=%0d got=%h exp=%h", k, obs, mexp()); end
    end
    n_run++;
    if (obs !== {3'b110, 2'd0, 8'd0, 8'd0}) begin n_fail++; $display("FAIL reset_values got=%h exp=%h", obs, {3'b110, 2'd0, 16'd0}); end
  endtask
  task automatic test_clean_lock();
    int pr_fall = -1, cr_fall = -1;
    for (int k = 1; k <= 60; k++) begin
      step(1'b0, 1'b0, k > 10);
      n_run++;
      if (obs !== mexp()) begin n_fail++; $display("FAIL clean_cycle k=%0d got=%h exp=%h", k, obs, mexp()); end
      if (pll_rst === 1'b0 && pr_fall < 0) pr_fall = k;
      if (core_reset === 1'b0 && cr_fall < 0) cr_fall = k;
    end
    n_run++;
    if (pr_fall != P) begin n_fail++; $display("FAIL clean_pll_rst_release got=%0d exp=%0d", pr_fall, P); end
    n_run++;
    if (cr_fall - 10 != 3 + S) begin n_fail++; $display("FAIL clean_core_latency got=%0d exp=%0d", cr_fall - 10, 3 + S); end
    n_run++;
    if ({ready, state, retry_count, lock_lost_count} !== {1'b1, 2'd3, 16'd0}) begin
      n_fail++; $display("FAIL clean_run_state got=%h exp=%h", {ready, state, retry_count, lock_lost_count}, {1'b1, 2'd3, 16'd0});
    end
  endtask
  task automatic test_loss_of_lock();
    int rise = -1, fall = -1;
    step(1'b0, 1'($urandom_range(0, 1)) & 1'b0, 1'b0);
    n_run++;
    if (obs !== mexp()) begin n_fail++; $display("FAIL loss_drop got=%h exp=%h", obs, mexp()); end
    for (int j = 1; j <= 40; j++) begin
      step(1'b0, 1'b0, 1'b1);
      n_run++;
      if (obs !== mexp()) begin n_fail++; $display("FAIL loss_cycle j=%0d got=%h exp=%h", j, obs, mexp()); end
      if (core_reset === 1'b1 && rise < 0) rise = j;
      if (core_reset === 1'b0 && rise > 0 && fall < 0) fall = j;
    end
    n_run++;
    if (rise + 1 != 3) begin n_fail++; $display("FAIL loss_assert_edges got=%0d exp=3", rise + 1); end
    n_run++;
    if (fall != 3 + S) begin n_fail++; $display("FAIL loss_relock_latency got=%0d exp=%0d", fall, 3 + S); end
    n_run++;
    if (lock_lost_count !== 8'd1) begin n_fail++; $display("FAIL loss_count got=%0d exp=1", lock_lost_count); end
  endtask
  task automatic test_soft_reset();
    logic [W-1:0] r0, l0;
    int high = 0;
    r0 = retry_count; l0 = lock_lost_count;
    step(1'b0, 1'b1, 1'b1);
    if (core_reset === 1'b1) high++;
    for (int j = 0; j < 30; j++) begin
      step(1'b0, 1'b0, 1'b1);
      n_run++;
      if (obs !== mexp()) begin n_fail++; $display("FAIL soft_cycle j=%0d got=%h exp=%h", j, obs, mexp()); end
      if (core_reset === 1'b1) high++;
    end
    n_run++;
    if (high != S) begin n_fail++; $display("FAIL soft_core_high got=%0d exp=%0d", high, S); end
    n_run++;
    if ({state, retry_count, lock_lost_count} !== {2'd3, r0, l0}) begin
      n_fail++; $display("FAIL soft_counters got=%h exp=%h", {state, retry_count, lock_lost_count}, {2'd3, r0, l0});
    end
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b1, 1'b1);
    n_run++;
    if ({state, retry_count, lock_lost_count} !== {2'd1, r0, l0 + 8'd1}) begin
      n_fail++; $display("FAIL soft_priority got=%h exp=%h", {state, retry_count, lock_lost_count}, {2'd1, r0, l0 + 8'd1});
    end
    for (int j = 0; j < 30; j++) begin
      step(1'b0, 1'($urandom_range(0, 7) == 0), 1'b1);
      n_run++;
      if (obs !== mexp()) begin n_fail++; $display("FAIL soft_random j=%0d got=%h exp=%h", j, obs, mexp()); end
    end
  endtask
  task automatic test_timeout_retry();
    int wrun = 0, prun = 0;
    bit seen_wait = 0, core_fell = 0;
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    for (int k = 1; k <= 320; k++) begin
      step(1'b0, 1'($urandom_range(0, 1)), 1'b0);
      n_run++;
      if (obs !== mexp()) begin n_fail++; $display("FAIL timeout_cycle k=%0d got=%h exp=%h", k, obs, mexp()); end
      if (core_reset !== 1'b1) core_fell = 1;
      if (state === 2'd1) begin
        wrun++; seen_wait = 1;
      end else if (wrun > 0) begin
        n_run++;
        if (wrun != LT) begin n_fail++; $display("FAIL timeout_wait_len got=%0d exp=%0d", wrun, LT); end
        wrun = 0;
      end
      if (pll_rst === 1'b1 && seen_wait) prun++;
      else if (prun > 0) begin
        n_run++;
        if (prun != P) begin n_fail++; $display("FAIL timeout_pll_rst_len got=%0d exp=%0d", prun, P); end
        prun = 0;
      end
    end
    n_run++;
    if (retry_count !== 8'd3) begin n_fail++; $display("FAIL timeout_retry_count got=%0d exp=3", retry_count); end
    n_run++;
    if (core_fell) begin n_fail++; $display("FAIL timeout_core_fell got=1 exp=0"); end
  endtask
  task automatic test_flapping();
    int run = 0;
    bit done = 0, reached = 0;
    step(1'b1, 1'b0, 1'b0);
    for (int k = 1; k <= 130; k++) begin
      step(1'b0, 1'b0, ((k - 1) % 12) < 10);
      n_run++;
      if (obs !== mexp()) begin n_fail++; $display("FAIL flap_cycle k=%0d got=%h exp=%h", k, obs, mexp()); end
      if (state === 2'd3) reached = 1;
      if ((state === 2'd1 || state === 2'd2) && !done) run++;
      else if (run > 0) done = 1;
    end
    n_run++;
    if (run != LT) begin n_fail++; $display("FAIL flap_timeout_len got=%0d exp=%0d", run, LT); end
    n_run++;
    if (reached) begin n_fail++; $display("FAIL flap_reached_run got=1 exp=0"); end
    n_run++;
    if (retry_count !== 8'd1) begin n_fail++; $display("FAIL flap_retry_count got=%0d exp=1", retry_count); end
  endtask
  task automatic test_random();
    step(1'b1, 1'b0, 1'b0);
    for (int k = 0; k < 2000; k++) begin
      step(1'($urandom_range(0, 499) == 0), 1'($urandom_range(0, 15) == 0), 1'($urandom_range(0, 39) != 0));
      n_run++;
      if (obs !== mexp()) begin n_fail++; $display("FAIL random_cycle k=%0d got=%h exp=%h", k, obs, mexp()); end
    end
  endtask
  task automatic test_saturation();
    int guard = 0;
    step(1'b1, 1'b0, 1'b0);
    for (int k = 1; k <= 260 * (P + LT) + 10; k++) begin
      step(1'b0, 1'b0, 1'b0);
      n_run++;
      if (obs !== mexp()) begin n_fail++; $display("FAIL sat_cycle k=%0d got=%h exp=%h", k, obs, mexp()); end
    end
    n_run++;
    if (retry_count !== 8'd255) begin n_fail++; $display("FAIL sat_retry_count got=%0d exp=255", retry_count); end
    while (state !== 2'd2 && guard < 50) begin
      step(1'b0, 1'b0, 1'b1);
      guard++;
    end
    n_run++;
    if (state !== 2'd2) begin n_fail++; $display("FAIL sat_reach_stable got=%0d exp=2", state); end
    step(1'b1, 1'b0, 1'b1);
    n_run++;
    if (obs !== {3'b110, 2'd0, 16'd0}) begin n_fail++; $display("FAIL sat_mid_reset got=%h exp=%h", obs, {3'b110, 2'd0, 16'd0}); end
  endtask
  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end
  initial begin
    test_reset();
    test_clean_lock();
    test_loss_of_lock();
    test_soft_reset();
    test_timeout_retry();
    test_flapping();
    test_random();
    test_saturation();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
